// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// State encoding, counter sizing and relock-count width.
package pll_seq_pkg;

   localparam int RELOCK_W = 8;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN,
      FAIL
   } state_t;

   function automatic int cnt_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_ff2.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Synchronous active-high reset clears both stages.
module sync_ff2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: reset pulse, lock debounce/timeout/retry,
// staggered domain reset release and lock-loss recovery.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int NUM_OUTPUTS         = 3,
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int STAGGER_CYCLES      = 8,
   parameter int MAX_RETRIES         = 4
) (
   input  logic                   i_clk,
   input  logic                   reset,
   input  logic                   i_locked,
   input  logic                   i_clear,
   output logic                   o_pll_reset,
   output logic [NUM_OUTPUTS-1:0] o_rst,
   output logic                   o_ready,
   output logic                   o_fail,
   output logic [RELOCK_W-1:0]    o_relock_count
);

   localparam int PMAX = (RST_PULSE_CYCLES > STAGGER_CYCLES) ?
                         RST_PULSE_CYCLES : STAGGER_CYCLES;
   localparam int PW = cnt_w(PMAX);
   localparam int TW = cnt_w(LOCK_TIMEOUT_CYCLES);
   localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
   localparam int RW = cnt_w(MAX_RETRIES);

   localparam logic [PW-1:0] P_END = PW'(RST_PULSE_CYCLES - 1);
   localparam logic [PW-1:0] G_END = PW'(STAGGER_CYCLES - 1);
   localparam logic [TW-1:0] T_END = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] S_END = SW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RW-1:0] R_END = RW'(MAX_RETRIES);
   localparam logic [NUM_OUTPUTS-1:0] ONES = '1;

   state_t        state;
   logic [PW-1:0] pcnt;
   logic [TW-1:0] tcnt;
   logic [SW-1:0] scnt;
   logic [RW-1:0] rcnt;
   logic [RW-1:0] rcnt_nxt;
   logic          lk;
   logic          timeout;

   sync_ff2 #(.WIDTH(1)) u_lock_sync (
      .clk   (i_clk),
      .reset (reset),
      .d     (i_locked),
      .q     (lk)
   );

   assign timeout     = (tcnt == T_END);
   assign rcnt_nxt    = rcnt + 1'b1;
   assign o_pll_reset = (state == PLL_RST) || (state == FAIL);
   assign o_ready     = (state == RUN);
   assign o_fail      = (state == FAIL);

   always_ff @(posedge i_clk) begin
      if (reset) begin
         state <= PLL_RST;
         pcnt  <= '0;
         tcnt  <= '0;
         scnt  <= '0;
         rcnt  <= '0;
         o_rst <= '1;
      end else begin
         unique case (state)
            PLL_RST: begin
               tcnt <= '0;
               scnt <= '0;
               if (pcnt == P_END) begin
                  pcnt  <= '0;
                  state <= WAIT_LOCK;
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            WAIT_LOCK, STABLE: begin
               tcnt <= tcnt + 1'b1;
               // Timeout wins even if the debounce completes this cycle.
               if (timeout) begin
                  rcnt  <= rcnt_nxt;
                  scnt  <= '0;
                  state <= (rcnt_nxt == R_END) ? FAIL : PLL_RST;
               end else if (!lk) begin
                  scnt  <= '0;
                  state <= WAIT_LOCK;
               end else if (scnt == S_END) begin
                  scnt  <= '0;
                  pcnt  <= '0;
                  o_rst <= ONES << 1;
                  state <= RELEASE;
               end else begin
                  scnt  <= scnt + 1'b1;
                  state <= STABLE;
               end
            end
            RELEASE: begin
               if (!lk) begin
                  o_rst <= '1;
                  pcnt  <= '0;
                  state <= PLL_RST;
               end else if (pcnt == G_END) begin
                  pcnt <= '0;
                  if (o_rst == '0) state <= RUN;
                  else o_rst <= o_rst << 1;
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            RUN: begin
               if (!lk) begin
                  o_rst <= '1;
                  rcnt  <= '0;
                  pcnt  <= '0;
                  state <= PLL_RST;
               end
            end
            FAIL: state <= FAIL;
            default: state <= PLL_RST;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (reset || i_clear) begin
         o_relock_count <= '0;
      end else if (state == RUN && !lk && o_relock_count != '1) begin
         o_relock_count <= o_relock_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed timing scenarios plus
// randomized lock traffic against a timestamp-based reference model.
module tb_pll_reset_sequencer;

   localparam int N  = 3;
   localparam int RP = 4;
   localparam int LS = 8;
   localparam int TO = 32;
   localparam int SG = 3;
   localparam int MR = 2;

   localparam int PH_PULSE = 0;
   localparam int PH_WAIT  = 1;
   localparam int PH_REL   = 2;
   localparam int PH_RUN   = 3;
   localparam int PH_FAIL  = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         i_locked;
   logic         i_clear;
   logic         o_pll_reset;
   logic [N-1:0] o_rst;
   logic         o_ready;
   logic         o_fail;
   logic [7:0]   o_relock_count;

   int tests = 0;
   int fails = 0;

   int ph, t0, cyc, run_len, retries, relocks, rbase;
   bit s1, s2, model_on;

   always #5 clk = ~clk;

   pll_reset_sequencer #(
      .NUM_OUTPUTS         (N),
      .RST_PULSE_CYCLES    (RP),
      .LOCK_STABLE_CYCLES  (LS),
      .LOCK_TIMEOUT_CYCLES (TO),
      .STAGGER_CYCLES      (SG),
      .MAX_RETRIES         (MR)
   ) dut (
      .i_clk          (clk),
      .reset          (reset),
      .i_locked       (i_locked),
      .i_clear        (i_clear),
      .o_pll_reset    (o_pll_reset),
      .o_rst          (o_rst),
      .o_ready        (o_ready),
      .o_fail         (o_fail),
      .o_relock_count (o_relock_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int now();
      return cyc - rbase;
   endfunction

   // One clock edge of the reference model; s2 is lk of the prior cycle.
   task automatic model_edge(input bit r, input bit l, input bit c);
      cyc++;
      if (r) begin
         model_on = 1'b1;
         rbase = cyc;
         ph = PH_PULSE;
         t0 = cyc;
         run_len = 0;
         retries = 0;
         relocks = 0;
         s1 = 1'b0;
         s2 = 1'b0;
         return;
      end
      if (ph == PH_PULSE) begin
         if (cyc - t0 == RP) begin
            ph = PH_WAIT;
            t0 = cyc;
            run_len = 0;
         end
      end else if (ph == PH_WAIT) begin
         if (cyc - t0 == TO) begin
            retries++;
            if (retries == MR) ph = PH_FAIL;
            else begin
               ph = PH_PULSE;
               t0 = cyc;
            end
         end else if (s2) begin
            run_len++;
            if (run_len == LS) begin
               ph = PH_REL;
               t0 = cyc;
            end
         end else begin
            run_len = 0;
         end
      end else if (ph == PH_REL) begin
         if (!s2) begin
            ph = PH_PULSE;
            t0 = cyc;
         end else if (cyc - t0 == N * SG) begin
            ph = PH_RUN;
         end
      end else if (ph == PH_RUN) begin
         if (!s2) begin
            if (relocks < 255) relocks++;
            retries = 0;
            ph = PH_PULSE;
            t0 = cyc;
         end
      end
      if (c) relocks = 0;
      s2 = s1;
      s1 = l;
   endtask

   function automatic logic [31:0] model_out();
      logic [N-1:0] r;
      r = '1;
      if (ph == PH_REL) begin
         for (int k = 0; k < N; k++) r[k] = ((cyc - t0) < k * SG);
      end else if (ph == PH_RUN) begin
         r = '0;
      end
      return {18'b0, (ph == PH_PULSE || ph == PH_FAIL), r,
              (ph == PH_RUN), (ph == PH_FAIL), relocks[7:0]};
   endfunction

   function automatic logic [31:0] dut_out();
      return {18'b0, o_pll_reset, o_rst, o_ready, o_fail,
              o_relock_count};
   endfunction

   task automatic tick(input bit r, input bit l, input bit c);
      reset = r;
      i_locked = l;
      i_clear = c;
      @(posedge clk);
      model_edge(r, l, c);
      #1;
      if (model_on) chk("model", dut_out(), model_out());
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 60 && !o_ready; i++) tick(0, 1, 0);
      chk(tag, o_ready, 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pll"}, o_pll_reset, 1);
      chk({tag, "_rst"}, o_rst, 3'b111);
      chk({tag, "_ready"}, o_ready, 0);
      chk({tag, "_fail"}, o_fail, 0);
      chk({tag, "_cnt"}, o_relock_count, 0);
   endtask

   initial begin
      int fp, fy, ffail, pulses, hold;
      int fr[N];
      bit prev, lock;

      cyc = 0;
      rbase = 0;
      model_on = 1'b0;

      // reset state
      tick(1, 0, 0);
      tick(1, 0, 0);
      chk_reset_vals("reset");

      // nominal bring-up, lock rises at edge 10
      fp = -1;
      fy = -1;
      for (int k = 0; k < N; k++) fr[k] = -1;
      for (int c = 0; c < 40; c++) begin
         tick(0, c >= 10, 0);
         if (fp < 0 && !o_pll_reset) fp = now();
         for (int k = 0; k < N; k++)
            if (fr[k] < 0 && !o_rst[k]) fr[k] = now();
         if (fy < 0 && o_ready) fy = now();
      end
      chk("nom_pll_low", fp, RP);
      chk("nom_rst0", fr[0], 20);
      chk("nom_rst1", fr[1], 23);
      chk("nom_rst2", fr[2], 26);
      chk("nom_ready", fy, 29);

      // lock loss in RUN at F = 40
      tick(0, 0, 0);
      tick(0, 1, 0);
      chk("loss_f2_ready", o_ready, 1);
      tick(0, 1, 0);
      chk("loss_rst", o_rst, 3'b111);
      chk("loss_ready", o_ready, 0);
      chk("loss_pll", o_pll_reset, 1);
      chk("loss_cnt", o_relock_count, 1);
      fy = -1;
      for (int c = 0; c < 40 && fy < 0; c++) begin
         tick(0, 1, 0);
         if (o_ready) fy = now();
      end
      chk("relock_ready", fy, 40 + 3 + RP + LS + N * SG);

      // glitchy lock: high 5, low 1, then steady
      tick(1, 0, 0);
      fr[0] = -1;
      for (int c = 0; c < 40; c++) begin
         tick(0, (c >= 10 && c <= 14) || c >= 16, 0);
         if (fr[0] < 0 && !o_rst[0]) fr[0] = now();
      end
      chk("glitch_rel", fr[0], 26);

      // timeout and failure with lock never arriving
      tick(1, 0, 0);
      ffail = -1;
      pulses = 1;
      prev = 1'b1;
      for (int c = 0; c < 100; c++) begin
         tick(0, 0, 0);
         if (ffail < 0 && o_fail) ffail = now();
         if (ffail < 0 && o_pll_reset && !prev) pulses++;
         prev = o_pll_reset;
      end
      chk("to_pulses", pulses, MR);
      chk("to_fail_at", ffail, MR * (RP + TO));
      for (int c = 0; c < 30; c++) tick(0, 1, 0);
      chk("to_stuck_fail", o_fail, 1);
      chk("to_stuck_pll", o_pll_reset, 1);
      chk("to_stuck_rst", o_rst, 3'b111);
      tick(1, 1, 0);
      chk("to_reset_clear", o_fail, 0);

      // relock counter saturation and clear priority
      wait_ready("cnt_first_ready");
      for (int i = 0; i < 300; i++) begin
         tick(0, 0, 0);
         tick(0, 1, 0);
         tick(0, 1, 0);
         wait_ready("cnt_ready");
      end
      chk("cnt_sat", o_relock_count, 255);
      tick(0, 0, 0);
      tick(0, 1, 0);
      tick(0, 1, 1);
      chk("clr_coincide", o_relock_count, 0);
      wait_ready("clr_ready");
      tick(0, 0, 0);
      tick(0, 1, 0);
      tick(0, 1, 0);
      chk("cnt_after_clr", o_relock_count, 1);

      // reset in the middle of RELEASE
      tick(1, 1, 0);
      for (int c = 0; c < 60 && o_rst != 3'b110; c++) tick(0, 1, 0);
      chk("mid_reached", o_rst, 3'b110);
      tick(1, 1, 0);
      chk_reset_vals("mid_reset");

      // randomized lock traffic against the model
      tick(1, 0, 0);
      lock = 1'b0;
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         if (hold == 0) begin
            lock = !lock;
            if (lock) hold = $urandom_range(1, 80);
            else if ($urandom_range(0, 5) == 0) hold = $urandom_range(20, 90);
            else hold = $urandom_range(1, 4);
         end
         hold--;
         tick($urandom_range(0, 399) == 0, lock, $urandom_range(0, 99) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Supervises one ECP5 PLL (EHXPLLL wrapper) and sequences the resets of the clock domains it feeds.
- Pulses the PLL reset after power-up.
- Waits for a debounced lock, retrying on timeout; gives up after a fixed number of retries.
- Releases NUM_OUTPUTS downstream domain resets in a staggered order.
- On lock loss: re-asserts all domain resets, re-runs the sequence and counts the event.

Sits between the board clock input and the SoC reset tree. Clocked from the PLL reference clock, never from a PLL output.

## Interface
Parameters:
- NUM_OUTPUTS, 3: number of staggered domain reset outputs (1..16)
- RST_PULSE_CYCLES, 16: cycles o_pll_reset stays high per attempt (>=1)
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock-high cycles required (>=1)
- LOCK_TIMEOUT_CYCLES, 65536: maximum wait for lock per attempt (>LOCK_STABLE_CYCLES)
- STAGGER_CYCLES, 8: spacing between successive reset releases (>=1)
- MAX_RETRIES, 4: timed-out attempts allowed before failure (>=1)

Ports:
- i_clk  in  1  reference clock (25 MHz board oscillator)
- reset  in  1  synchronous, active-high
- i_locked  in  1  raw PLL LOCK, asynchronous to i_clk
- i_clear  in  1  clears o_relock_count
- o_pll_reset  out  1  drives PLL RST
- o_rst  out  NUM_OUTPUTS  per-domain reset, active-high
- o_ready  out  1  all domains released, lock good
- o_fail  out  1  retries exhausted
- o_relock_count  out  8  saturating count of lock-loss events in RUN

## Operation
Lock synchroniser:
- i_locked passes through two flops; the result is lk.
- Only lk is used internally.

State machine:
- PLL_RST: o_pll_reset=1; count RST_PULSE_CYCLES, then go to WAIT_LOCK.
- WAIT_LOCK: timeout counter runs. When lk=1, go to STABLE.
  - Timeout reaches LOCK_TIMEOUT_CYCLES: increment the retry counter.
  - If the retry counter equals MAX_RETRIES, go to FAIL; otherwise go to PLL_RST.
- STABLE: stable counter runs while lk=1; the timeout counter keeps running.
  - lk=0: clear the stable counter, return to WAIT_LOCK.
  - Stable counter reaches LOCK_STABLE_CYCLES: go to RELEASE.
  - A timeout in STABLE is handled exactly as a timeout in WAIT_LOCK.
- RELEASE: o_rst[0] clears on entry. o_rst[k] clears STAGGER_CYCLES after o_rst[k-1]. After the last bit clears, wait STAGGER_CYCLES, then go to RUN.
  - lk=0 during RELEASE: set all o_rst, go to PLL_RST. Not counted as a relock.
- RUN: o_ready=1. On lk=0:
  - set all o_rst and clear o_ready on the next cycle;
  - o_relock_count increments, saturating at 255;
  - the retry counter clears;
  - go to PLL_RST.
- FAIL: o_pll_reset=1, all o_rst=1, o_fail=1. Exit only via reset.

Other rules:
- Released o_rst bits stay low until a lock loss or reset.
- i_clear zeroes o_relock_count. When i_clear coincides with an increment, i_clear wins and the result is 0.
- reset at any cycle aborts the sequence and takes effect on the next edge.

Reset values:
- o_pll_reset=1, o_rst=all 1, o_ready=0, o_fail=0, o_relock_count=0.
- State PLL_RST; all counters 0; synchroniser flops 0.

## Timing
- Reset low from edge 0: o_pll_reset is high for cycles 0..RST_PULSE_CYCLES-1 and low from cycle RST_PULSE_CYCLES.
- i_locked rising at edge L (steady afterwards): lk=1 from L+2; RELEASE entered at L+2+LOCK_STABLE_CYCLES.
- From RELEASE entry cycle R:
  - o_rst[k] low from R+k·STAGGER_CYCLES;
  - o_ready high from R+NUM_OUTPUTS·STAGGER_CYCLES.
- Lock loss: i_locked falling at edge F gives lk=0 at F+2. At F+3, o_rst=all 1, o_ready=0, o_pll_reset=1 and the count is updated.
- Counter widths: $clog2(max parameter + 1). All comparisons are equality on terminal count.

## Structure
Shared package pll_seq_pkg holds:
- state enum (PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL);
- counter-width function;
- relock-count width constant (8).

One sub-module, sync_ff2: generic two-flop synchroniser, reusable for other asynchronous inputs.

## Test plan
All scenarios use NUM_OUTPUTS=3, RST_PULSE=4, LOCK_STABLE=8, TIMEOUT=32, STAGGER=3, MAX_RETRIES=2.
- Nominal: reset release, i_locked rises at edge 10 -> o_pll_reset low at 4; o_rst[0..2] low at 20/23/26; o_ready at 29.
- Glitchy lock: i_locked high 5 cycles, low 1, then steady -> the stable count restarts; release occurs 8 cycles after the final lk rise.
- Timeout/fail: i_locked held 0 -> two PLL_RST pulses, then o_fail=1 with o_pll_reset=1; stays failed until reset.
- Lock loss in RUN: drop i_locked at F -> o_rst=3'b111 and o_ready=0 at F+3; o_relock_count=1; full sequence repeats.
- Counter: 300 lock losses -> o_relock_count=255. i_clear coinciding with an increment -> 0.
- Mid-sequence reset: assert reset during RELEASE with o_rst=3'b110 -> next cycle all outputs are at their reset values.
